pantalla_wb: RTL and testbench

- Wishbone (classic, 32-bit) slave that fronts a small on-chip LCD frame buffer for the PH-LCD module.
- Software sets cursor X/Y, pixel colour and fill mode through memory-mapped registers.
- Software then triggers a single-pixel write or a hardware fill operation and polls a status register.
- The frame buffer is internal; the panel-driving side is out of scope for this block.

---
 rtl/pantalla_pkg.sv | 30 +++
 rtl/pantalla_fb.sv | 26 ++
 rtl/pantalla_wb.sv | 187 ++++++++++++++++++
 tb/tb_pantalla_wb.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pantalla_pkg.sv
// Shared definitions for the PH-LCD frame-buffer slave: register word offsets,
// fill-mode encodings and the fill-engine state enum.
package pantalla_pkg;

    localparam int unsigned REG_SEL_W = 3;

    // Word offsets decoded from wb_adr_i[4:2]
    localparam logic [REG_SEL_W-1:0] REG_CTRL  = 3'd0;
    localparam logic [REG_SEL_W-1:0] REG_PIXWR = 3'd1;
    localparam logic [REG_SEL_W-1:0] REG_X     = 3'd2;
    localparam logic [REG_SEL_W-1:0] REG_Y     = 3'd3;
    localparam logic [REG_SEL_W-1:0] REG_DATA  = 3'd4;
    localparam logic [REG_SEL_W-1:0] REG_MODE  = 3'd5;
    localparam logic [REG_SEL_W-1:0] REG_PIXRD = 3'd6;
    localparam logic [REG_SEL_W-1:0] REG_RSVD  = 3'd7;

    typedef enum logic [1:0] {
        MODE_PIXEL = 2'd0,
        MODE_ROW   = 2'd1,
        MODE_COL   = 2'd2,
        MODE_ALL   = 2'd3
    } fill_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } eng_state_e;

endpackage

// File: rtl/pantalla_fb.sv
// Single-port synchronous frame-buffer RAM with registered (read-first) output.
// Ports: clk; we/addr/wdata write port; rdata = mem[addr] from the previous cycle.
// Contents are deliberately not reset.
module pantalla_fb #(
    parameter int unsigned AW    = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    localparam int unsigned DEPTH = 2 ** AW;

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/pantalla_wb.sv
// Wishbone classic 32-bit slave fronting the PH-LCD frame buffer.
// Ports: clk, rst (async, active-low); wb_stb_i/wb_cyc_i/wb_we_i/wb_adr_i/
// wb_sel_i/wb_dat_i requests; wb_ack_o (one-cycle registered ack) and
// wb_dat_o (registered read data, zero outside read acks).
// Holds the cursor/colour/mode registers and the fill engine; the engine owns
// the RAM port while it runs, otherwise the port follows the cursor.
module pantalla_wb
    import pantalla_pkg::*;
#(
    parameter int unsigned H_RES = 16,
    parameter int unsigned V_RES = 16,
    parameter int unsigned PIX_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    output logic        wb_ack_o,
    input  logic        wb_we_i,
    input  logic [31:0] wb_adr_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o
);

    localparam int unsigned XW = $clog2(H_RES);
    localparam int unsigned YW = $clog2(V_RES);
    localparam int unsigned AW = XW + YW;

    // Byte selects and undecoded address bits have no function
    logic unused_c;
    assign unused_c = ^{wb_sel_i, wb_adr_i[31:5], wb_adr_i[1:0], wb_dat_i};

    logic [REG_SEL_W-1:0] reg_sel_c;
    logic                 req_c, wr_c, rd_c, start_c, pixwr_c, busy_c, last_c;

    eng_state_e state, state_next;

    logic [XW-1:0]    x_reg, cx;
    logic [YW-1:0]    y_reg, cy;
    logic [PIX_W-1:0] data_reg, eng_data;
    fill_mode_e       mode_reg, eng_mode;
    logic [AW-1:0]    rem, span_c;
    logic             done;

    logic             fb_we_c;
    logic [AW-1:0]    fb_addr_c;
    logic [PIX_W-1:0] fb_wdata_c, fb_rdata;
    logic [31:0]      rd_data_c;

    // Bus decode: a request is accepted only when ack is low
    assign reg_sel_c = wb_adr_i[4:2];
    assign req_c     = wb_stb_i & wb_cyc_i & ~wb_ack_o;
    assign wr_c      = req_c & wb_we_i;
    assign rd_c      = req_c & ~wb_we_i;
    assign busy_c    = (state == ST_RUN);
    assign last_c    = (rem == '0);
    assign start_c   = wr_c && (reg_sel_c == REG_CTRL)  && wb_dat_i[0] && !busy_c;
    assign pixwr_c   = wr_c && (reg_sel_c == REG_PIXWR) && wb_dat_i[0] && !busy_c;

    // Wishbone ack and read data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            wb_ack_o <= req_c;
            wb_dat_o <= rd_c ? rd_data_c : '0;
        end
    end

    // Read mux
    always_comb begin
        rd_data_c = '0;
        unique case (reg_sel_c)
            REG_CTRL:  rd_data_c = {30'b0, done, busy_c};
            REG_X:     rd_data_c = 32'(x_reg);
            REG_Y:     rd_data_c = 32'(y_reg);
            REG_DATA:  rd_data_c = 32'(data_reg);
            REG_MODE:  rd_data_c = 32'(mode_reg);
            REG_PIXRD: rd_data_c = 32'(fb_rdata);
            default:   rd_data_c = '0;
        endcase
    end

    // Software-visible registers; writes land even while the engine runs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_reg    <= '0;
            y_reg    <= '0;
            data_reg <= '0;
            mode_reg <= MODE_PIXEL;
        end else if (wr_c) begin
            unique case (reg_sel_c)
                REG_X:    x_reg    <= wb_dat_i[XW-1:0];
                REG_Y:    y_reg    <= wb_dat_i[YW-1:0];
                REG_DATA: data_reg <= wb_dat_i[PIX_W-1:0];
                REG_MODE: mode_reg <= fill_mode_e'(wb_dat_i[1:0]);
                default:  ;
            endcase
        end
    end

    // Fill engine state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Fill engine next state; DONE is a one-cycle pass-through back to IDLE
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: if (start_c) state_next = ST_RUN;
            ST_RUN:  if (last_c)  state_next = ST_DONE;
            ST_DONE: state_next = start_c ? ST_RUN : ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Pixel count minus one for the selected mode
    always_comb begin
        span_c = '0;
        unique case (mode_reg)
            MODE_PIXEL: span_c = '0;
            MODE_ROW:   span_c = AW'(H_RES - 1);
            MODE_COL:   span_c = AW'(V_RES - 1);
            MODE_ALL:   span_c = AW'(H_RES * V_RES - 1);
            default:    span_c = '0;
        endcase
    end

    // Engine datapath: latch parameters on start, then walk row-major
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cx       <= '0;
            cy       <= '0;
            rem      <= '0;
            eng_data <= '0;
            eng_mode <= MODE_PIXEL;
            done     <= 1'b0;
        end else if (start_c) begin
            cx       <= (mode_reg == MODE_PIXEL || mode_reg == MODE_COL) ? x_reg : '0;
            cy       <= (mode_reg == MODE_PIXEL || mode_reg == MODE_ROW) ? y_reg : '0;
            rem      <= span_c;
            eng_data <= data_reg;
            eng_mode <= mode_reg;
            done     <= 1'b0;
        end else if (busy_c) begin
            rem <= rem - AW'(1);
            if (last_c) begin
                done <= 1'b1;
            end
            unique case (eng_mode)
                MODE_ROW: cx <= cx + XW'(1);
                MODE_COL: cy <= cy + YW'(1);
                MODE_ALL: begin
                    cx <= cx + XW'(1);
                    if (&cx) begin
                        cy <= cy + YW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // RAM port: engine while running, cursor otherwise (also feeds PIXRD)
    assign fb_we_c    = busy_c | pixwr_c;
    assign fb_addr_c  = busy_c ? {cy, cx} : {y_reg, x_reg};
    assign fb_wdata_c = busy_c ? eng_data : data_reg;

    pantalla_fb #(
        .AW    (AW),
        .WIDTH (PIX_W)
    ) u_fb (
        .clk   (clk),
        .we    (fb_we_c),
        .addr  (fb_addr_c),
        .wdata (fb_wdata_c),
        .rdata (fb_rdata)
    );

endmodule

// File: tb/tb_pantalla_wb.sv
// Directed bench for pantalla_wb: register access, pixel writes, each fill mode
// with exact busy-window timing, conflicts while busy, and reset mid-fill.
module tb_pantalla_wb;

    localparam logic [31:0] A_CTRL  = 32'h00;
    localparam logic [31:0] A_PIXWR = 32'h04;
    localparam logic [31:0] A_X     = 32'h08;
    localparam logic [31:0] A_Y     = 32'h0C;
    localparam logic [31:0] A_DATA  = 32'h10;
    localparam logic [31:0] A_MODE  = 32'h14;
    localparam logic [31:0] A_PIXRD = 32'h18;
    localparam logic [31:0] A_RSVD  = 32'h1C;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_stb_i, wb_cyc_i, wb_we_i, wb_ack_o;
    logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
    logic [3:0]  wb_sel_i;

    int errors = 0;
    int checks = 0;

    pantalla_wb #(.H_RES(16), .V_RES(16), .PIX_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .wb_stb_i (wb_stb_i),
        .wb_cyc_i (wb_cyc_i),
        .wb_ack_o (wb_ack_o),
        .wb_we_i  (wb_we_i),
        .wb_adr_i (wb_adr_i),
        .wb_sel_i (wb_sel_i),
        .wb_dat_i (wb_dat_i),
        .wb_dat_o (wb_dat_o)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat);
        logic got;
        got = 1'b0;
        wb_adr_i = adr; wb_dat_i = dat; wb_we_i = 1'b1; wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (wb_ack_o) begin got = 1'b1; break; end
        end
        wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
        if (!got) begin
            checks++; errors++;
            $display("FAIL write_ack_timeout: adr=%h got no ack, required ack", adr);
        end
    endtask

    task automatic wb_read(input logic [31:0] adr, output logic [31:0] d);
        logic got;
        got = 1'b0; d = 32'hDEAD_BEEF;
        wb_adr_i = adr; wb_we_i = 1'b0; wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (wb_ack_o) begin got = 1'b1; d = wb_dat_o; break; end
        end
        wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
        if (!got) begin
            checks++; errors++;
            $display("FAIL read_ack_timeout: adr=%h got no ack, required ack", adr);
        end
    endtask

    task automatic read_pix(input int x, input int y, output logic [31:0] d);
        wb_write(A_X, 32'(x));
        wb_write(A_Y, 32'(y));
        wb_read(A_PIXRD, d);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [31:0] adrs [7];
        adrs = '{A_CTRL, A_PIXWR, A_X, A_Y, A_DATA, A_MODE, A_RSVD};
        rst = 1'b0;
        wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
        wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = 4'hF;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (wb_ack_o !== 1'b0 || wb_dat_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: ack=%b dat=%h, required ack=0 dat=0", wb_ack_o, wb_dat_o);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        foreach (adrs[i]) begin
            wb_read(adrs[i], d);
            checks++;
            if (d !== 32'h0) begin
                errors++;
                $display("FAIL reset_reg_%h: got %h, required 0", adrs[i], d);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (wb_ack_o !== 1'b0) begin
            errors++;
            $display("FAIL ack_one_cycle: ack=%b one cycle after ack, required 0", wb_ack_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] pat;
        wb_adr_i = A_X; wb_we_i = 1'b0; wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            pat[i] = wb_ack_o;
        end
        wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
        checks++;
        if (pat !== 6'b010101) begin
            errors++;
            $display("FAIL held_strobe_ack_pattern: got %b, required 010101", pat);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_pixel();
        logic [31:0] d;
        wb_write(A_X, 32'h0);
        wb_write(A_Y, 32'h0);
        wb_write(A_DATA, 32'h50);
        wb_write(A_PIXWR, 32'h1);
        wb_write(A_DATA, 32'h77);
        wb_write(A_PIXWR, 32'h0);
        wb_read(A_PIXRD, d);
        checks++;
        if (d !== 32'h50) begin errors++; $display("FAIL pixrd_0_0: got %h, required 50", d); end
        wb_read(A_X, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL read_x: got %h, required 0", d); end
        wb_read(A_DATA, d);
        checks++;
        if (d !== 32'h77) begin errors++; $display("FAIL read_data: got %h, required 77", d); end
        wb_write(A_X, 32'h3);
        wb_write(A_Y, 32'h2);
        wb_write(A_DATA, 32'h3C);
        wb_write(A_PIXWR, 32'h1);
        wb_read(A_PIXRD, d);
        checks++;
        if (d !== 32'h3C) begin errors++; $display("FAIL pixrd_3_2: got %h, required 3c", d); end
        read_pix(0, 0, d);
        checks++;
        if (d !== 32'h50) begin errors++; $display("FAIL pixrd_0_0_kept: got %h, required 50", d); end
        wb_write(A_X, 32'h1F);
        wb_read(A_X, d);
        checks++;
        if (d !== 32'hF) begin errors++; $display("FAIL x_truncate: got %h, required f", d); end
        wb_write(A_MODE, 32'h7);
        wb_read(A_MODE, d);
        checks++;
        if (d !== 32'h3) begin errors++; $display("FAIL mode_truncate: got %h, required 3", d); end
        wb_read(A_PIXWR, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL pixwr_reads_zero: got %h, required 0", d); end
    endtask

    // Start a fill and check STATUS on the last busy cycle and the cycle after
    task automatic start_and_time(input int npix, input string tag);
        logic [31:0] d;
        wb_write(A_CTRL, 32'h1);
        repeat (npix - 1) @(posedge clk);
        #1;
        wb_read(A_CTRL, d);
        checks++;
        if (d !== 32'h1) begin errors++; $display("FAIL %s_busy_last: status %h, required 1", tag, d); end
        wb_read(A_CTRL, d);
        checks++;
        if (d !== 32'h2) begin errors++; $display("FAIL %s_done: status %h, required 2", tag, d); end
    endtask

    task automatic test_fill_all();
        logic [31:0] d;
        int px [3] = '{15, 7, 3};
        int py [3] = '{15, 3, 2};
        wb_write(A_MODE, 32'h3);
        wb_write(A_DATA, 32'h50);
        start_and_time(256, "fill_all");
        foreach (px[i]) begin
            read_pix(px[i], py[i], d);
            checks++;
            if (d !== 32'h50) begin
                errors++;
                $display("FAIL fill_all_pix_%0d_%0d: got %h, required 50", px[i], py[i], d);
            end
        end
    endtask

    task automatic test_fill_row();
        logic [31:0] d;
        int px [5] = '{0, 15, 9, 3, 3};
        int py [5] = '{5, 5, 5, 4, 6};
        logic [31:0] ex [5] = '{32'hAA, 32'hAA, 32'hAA, 32'h50, 32'h50};
        wb_write(A_MODE, 32'h1);
        wb_write(A_X, 32'h9);
        wb_write(A_Y, 32'h5);
        wb_write(A_DATA, 32'hAA);
        start_and_time(16, "fill_row");
        foreach (px[i]) begin
            read_pix(px[i], py[i], d);
            checks++;
            if (d !== ex[i]) begin
                errors++;
                $display("FAIL fill_row_pix_%0d_%0d: got %h, required %h", px[i], py[i], d, ex[i]);
            end
        end
    endtask

    task automatic test_fill_col();
        logic [31:0] d;
        int px [5] = '{2, 2, 2, 3, 1};
        int py [5] = '{0, 15, 5, 7, 9};
        logic [31:0] ex [5] = '{32'h33, 32'h33, 32'h33, 32'h50, 32'h50};
        wb_write(A_MODE, 32'h2);
        wb_write(A_X, 32'h2);
        wb_write(A_Y, 32'h9);
        wb_write(A_DATA, 32'h33);
        start_and_time(16, "fill_col");
        foreach (px[i]) begin
            read_pix(px[i], py[i], d);
            checks++;
            if (d !== ex[i]) begin
                errors++;
                $display("FAIL fill_col_pix_%0d_%0d: got %h, required %h", px[i], py[i], d, ex[i]);
            end
        end
    endtask

    task automatic test_conflicts();
        logic [31:0] d;
        wb_write(A_MODE, 32'h3);
        wb_write(A_DATA, 32'h50);
        wb_write(A_CTRL, 32'h1);         // fill starts at this ack edge (E1)
        wb_write(A_DATA, 32'h11);        // E3
        wb_write(A_CTRL, 32'h1);         // E5, restart must be ignored
        repeat (200) @(posedge clk);     // E205
        #1;
        wb_write(A_X, 32'h0);            // E207
        wb_write(A_Y, 32'h0);            // E209
        wb_write(A_PIXWR, 32'h1);        // E211, must be dropped
        repeat (45) @(posedge clk);      // E256
        #1;
        wb_read(A_CTRL, d);
        checks++;
        if (d !== 32'h1) begin errors++; $display("FAIL conflict_busy_last: status %h, required 1", d); end
        wb_read(A_CTRL, d);
        checks++;
        if (d !== 32'h2) begin errors++; $display("FAIL conflict_done: status %h, required 2", d); end
        wb_read(A_DATA, d);
        checks++;
        if (d !== 32'h11) begin errors++; $display("FAIL conflict_data_reg: got %h, required 11", d); end
        wb_read(A_PIXRD, d);
        checks++;
        if (d !== 32'h50) begin errors++; $display("FAIL conflict_pix_0_0: got %h, required 50", d); end
        read_pix(2, 5, d);
        checks++;
        if (d !== 32'h50) begin errors++; $display("FAIL conflict_pix_2_5: got %h, required 50", d); end
    endtask

    task automatic test_reset_mid_fill();
        logic [31:0] d;
        wb_write(A_MODE, 32'h3);
        wb_write(A_DATA, 32'h22);
        wb_write(A_CTRL, 32'h1);
        repeat (20) @(posedge clk);
        #1;
        wb_adr_i = A_CTRL; wb_we_i = 1'b0; wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (wb_ack_o !== 1'b1 || wb_dat_o !== 32'h1) begin
            errors++;
            $display("FAIL midfill_status: ack=%b dat=%h, required ack=1 dat=1", wb_ack_o, wb_dat_o);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (wb_ack_o !== 1'b0 || wb_dat_o !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: ack=%b dat=%h, required ack=0 dat=0", wb_ack_o, wb_dat_o);
        end
        wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        wb_read(A_CTRL, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL post_reset_status: got %h, required 0", d); end
        wb_read(A_MODE, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL post_reset_mode: got %h, required 0", d); end
        wb_write(A_X, 32'h4);
        wb_write(A_Y, 32'h4);
        wb_write(A_DATA, 32'h9C);
        wb_write(A_CTRL, 32'h1);
        wb_read(A_CTRL, d);
        checks++;
        if (d !== 32'h2) begin errors++; $display("FAIL restart_done: status %h, required 2", d); end
        wb_read(A_PIXRD, d);
        checks++;
        if (d !== 32'h9C) begin errors++; $display("FAIL single_pix_4_4: got %h, required 9c", d); end
        read_pix(5, 4, d);
        checks++;
        if (d !== 32'h50) begin errors++; $display("FAIL single_pix_5_4: got %h, required 50", d); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_pixel();
        test_fill_all();
        test_fill_row();
        test_fill_col();
        test_conflicts();
        test_reset_mid_fill();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
